// File: rtl/poly_reduce_sched.sv
`default_nettype none
// ============================================================================
//  Module   : poly_reduce_sched
//  Purpose  : Streams N polynomial coefficients from a source RAM port through
//             an external 2-stage mod-12289 Barrett reducer and writes the
//             14-bit results to a destination RAM port. One coefficient is
//             issued per cycle with no bubbles, then done pulses once.
//  Revision : 1.0  initial release
// ============================================================================
module poly_reduce_sched #(
   parameter int N        = 1024,
   parameter int AW       = 10,
   parameter int SRC_BASE = 0,
   parameter int DST_BASE = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   input  logic [15:0]   rd_data,
   output logic          red_en,
   output logic [15:0]   red_a,
   output logic          red_valid,
   input  logic          red_out_valid,
   input  logic [13:0]   red_result,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [13:0]   wr_data
);

   // Counters only need to hold 0..N-1; N never exceeds the address space.
   localparam int             CW      = (N > 2) ? $clog2(N) : 1;
   localparam logic [CW-1:0]  C_LAST  = CW'(N - 1);
   localparam logic [AW-1:0]  C_SRC   = AW'(SRC_BASE);
   localparam logic [AW-1:0]  C_DST   = AW'(DST_BASE);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_rd_cnt;
   logic [CW-1:0] r_wr_cnt;

   // Datapath pass-through: RAM output feeds the reducer, reducer feeds RAM.
   // Writes are gated by busy so a stray reducer valid while idle is dropped.
   assign red_a   = rd_data;
   assign wr_en   = red_out_valid & busy;
   assign wr_data = red_result;
   assign rd_addr = C_SRC + AW'(r_rd_cnt);
   assign wr_addr = C_DST + AW'(r_wr_cnt);

   // Reducer is held enabled whenever out of reset, giving a fixed 2-cycle latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         red_en <= 1'b0;
      end else begin
         red_en <= 1'b1;
      end
   end

   // Reducer input valid tracks the RAM read one cycle later (registered RAM).
   always_ff @(posedge clk) begin
      if (rst) begin
         red_valid <= 1'b0;
      end else begin
         red_valid <= rd_en;
      end
   end

   // Sweep sequencer: issue N reads back to back, drain until the N-th write
   // lands, then pulse done. start is only honoured in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         rd_en    <= 1'b0;
         r_rd_cnt <= '0;
         r_wr_cnt <= '0;
      end else begin
         done <= 1'b0;
         if (wr_en) begin
            r_wr_cnt <= r_wr_cnt + 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state  <= S_ISSUE;
                  busy     <= 1'b1;
                  rd_en    <= 1'b1;
                  r_rd_cnt <= '0;
                  r_wr_cnt <= '0;
               end
            end
            S_ISSUE: begin
               if (r_rd_cnt == C_LAST) begin
                  r_state <= S_DRAIN;
                  rd_en   <= 1'b0;
               end else begin
                  r_rd_cnt <= r_rd_cnt + 1'b1;
               end
            end
            S_DRAIN: begin
               // The final write always occurs here: writes trail reads by 3 cycles.
               if (wr_en && (r_wr_cnt == C_LAST)) begin
                  r_state <= S_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
               rd_en   <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_poly_reduce_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_poly_reduce_sched
//  Purpose  : Self-checking bench for poly_reduce_sched. Two instances (N=8
//             in place, N=256 with destination offset 512) share one RAM model
//             and have their own behavioural 2-stage mod-q reducer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_poly_reduce_sched;

   localparam int QM   = 12289;
   localparam int NA   = 8;
   localparam int NB   = 256;
   localparam int DSTB = 512;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst   = 1'b1;
   logic start = 1'b0;
   logic sel   = 1'b0;
   logic inj   = 1'b0;

   int errors = 0;
   int checks = 0;

   // ---------------- instance A: N=8, in place ----------------
   logic        busy_a, done_a, rd_en_a, red_en_a, red_valid_a, rov_a, wr_en_a;
   logic [9:0]  rd_addr_a, wr_addr_a;
   logic [15:0] rd_data_a, red_a_a;
   logic [13:0] rres_a, wr_data_a;

   poly_reduce_sched #(.N(NA), .AW(10), .SRC_BASE(0), .DST_BASE(0)) dut_a (
      .clk(clk), .rst(rst), .start(start & ~sel),
      .busy(busy_a), .done(done_a),
      .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
      .red_en(red_en_a), .red_a(red_a_a), .red_valid(red_valid_a),
      .red_out_valid(rov_a), .red_result(rres_a),
      .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a)
   );

   // ---------------- instance B: N=256, dst offset 512 ----------------
   logic        busy_b, done_b, rd_en_b, red_en_b, red_valid_b, rov_b, wr_en_b;
   logic [9:0]  rd_addr_b, wr_addr_b;
   logic [15:0] rd_data_b, red_a_b;
   logic [13:0] rres_b, wr_data_b;

   poly_reduce_sched #(.N(NB), .AW(10), .SRC_BASE(0), .DST_BASE(DSTB)) dut_b (
      .clk(clk), .rst(rst), .start(start & sel),
      .busy(busy_b), .done(done_b),
      .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
      .red_en(red_en_b), .red_a(red_a_b), .red_valid(red_valid_b),
      .red_out_valid(rov_b), .red_result(rres_b),
      .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b)
   );

   // Behavioural reducers: two register stages, cleared by the shared reset.
   logic [13:0] s1_a, s2_a, s1_b, s2_b;
   logic        s1v_a, s2v_a, s1v_b, s2v_b;
   always @(posedge clk) begin
      if (rst) begin
         s1v_a <= 1'b0; s2v_a <= 1'b0; s1v_b <= 1'b0; s2v_b <= 1'b0;
         s1_a <= '0; s2_a <= '0; s1_b <= '0; s2_b <= '0;
      end else begin
         if (red_en_a) begin
            s1v_a <= red_valid_a; s1_a <= 14'(int'(red_a_a) % QM);
            s2v_a <= s1v_a;       s2_a <= s1_a;
         end
         if (red_en_b) begin
            s1v_b <= red_valid_b; s1_b <= 14'(int'(red_a_b) % QM);
            s2v_b <= s1v_b;       s2_b <= s1_b;
         end
      end
   end
   assign rov_a  = s2v_a | (inj & ~sel);
   assign rov_b  = s2v_b | (inj & sel);
   assign rres_a = s2_a;
   assign rres_b = s2_b;

   // Shared registered RAM: instance A uses words 0..1023, B uses 1024..2047.
   logic [15:0] mem [2048];
   always @(posedge clk) begin
      if (rd_en_a) rd_data_a <= mem[{1'b0, rd_addr_a}];
      if (rd_en_b) rd_data_b <= mem[{1'b1, rd_addr_b}];
      if (wr_en_a) mem[{1'b0, wr_addr_a}] = {2'b00, wr_data_a};
      if (wr_en_b) mem[{1'b1, wr_addr_b}] = {2'b00, wr_data_b};
   end

   // Views of the currently selected instance.
   logic        m_busy, m_done, m_rd_en, m_wr_en, m_red_valid, m_red_en;
   logic [9:0]  m_rd_addr, m_wr_addr;
   logic [15:0] m_red_a, m_rd_data;
   logic [13:0] m_wr_data;
   assign m_busy      = sel ? busy_b      : busy_a;
   assign m_done      = sel ? done_b      : done_a;
   assign m_rd_en     = sel ? rd_en_b     : rd_en_a;
   assign m_wr_en     = sel ? wr_en_b     : wr_en_a;
   assign m_red_valid = sel ? red_valid_b : red_valid_a;
   assign m_red_en    = sel ? red_en_b    : red_en_a;
   assign m_rd_addr   = sel ? rd_addr_b   : rd_addr_a;
   assign m_wr_addr   = sel ? wr_addr_b   : wr_addr_a;
   assign m_red_a     = sel ? red_a_b     : red_a_a;
   assign m_rd_data   = sel ? rd_data_b   : rd_data_a;
   assign m_wr_data   = sel ? wr_data_b   : wr_data_a;

   // Reference source contents of the current sweep.
   int src [NB];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Load fresh source data for the selected instance; directed uses the
   // boundary vector around multiples of q for the first 8 words.
   task automatic fill(input bit directed);
      int n;
      int sidx;
      int didx;
      int dvec [8];
      dvec = '{0, 12288, 12289, 24578, 36866, 36867, 49151, 65535};
      n    = sel ? NB : NA;
      sidx = sel ? 1024 : 0;
      didx = sel ? 1024 + DSTB : 0;
      for (int k = 0; k < n; k++) begin
         src[k] = (directed && k < 8) ? dvec[k] : int'($urandom_range(0, 65535));
         mem[sidx + k] = 16'(src[k]);
         if (sel) mem[didx + k] = 16'hFFFF;
      end
   endtask

   // Destination must hold src mod q; a separate source region must be intact.
   task automatic check_mem();
      int n;
      int sidx;
      int didx;
      int expv;
      n    = sel ? NB : NA;
      sidx = sel ? 1024 : 0;
      didx = sel ? 1024 + DSTB : 0;
      for (int k = 0; k < n; k++) begin
         expv = src[k] % QM;
         chk("dst_word", 32'(mem[didx + k]), 32'(expv));
         if (sel) chk("src_intact", 32'(mem[sidx + k]), 32'(src[k]));
         else     src[k] = expv;
      end
   endtask

   // One sweep with a cycle-accurate expectation per relative cycle
   // (cycle 0 = first read). r1/r2 pulse start, rst_at pulses reset.
   // Returns while sampling cycle n+4, the first idle cycle after done.
   task automatic sweep(input int r1, input int r2, input int rst_at);
      int n;
      int nrd;
      int nwr;
      bit killed;
      bit live;
      n = sel ? NB : NA;
      nrd = 0;
      nwr = 0;
      killed = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int rel = 0; rel <= n + 4; rel++) begin
         live = !killed;
         chk("rd_en", 32'(m_rd_en), 32'(live && rel < n));
         chk("wr_en", 32'(m_wr_en), 32'(live && rel >= 3 && rel <= n + 2));
         chk("busy",  32'(m_busy),  32'(live && rel <= n + 2));
         chk("done",  32'(m_done),  32'(live && rel == n + 3));
         chk("red_valid", 32'(m_red_valid), 32'(live && rel >= 1 && rel <= n));
         if (live && rel < n) chk("rd_addr", 32'(m_rd_addr), 32'(rel));
         if (live && rel >= 1 && rel <= n) chk("red_a", 32'(m_red_a), 32'(m_rd_data));
         if (live && rel >= 3 && rel <= n + 2) begin
            chk("wr_addr", 32'(m_wr_addr), 32'((sel ? DSTB : 0) + rel - 3));
            chk("wr_data", 32'(m_wr_data), 32'(src[rel - 3] % QM));
         end
         nrd += int'(m_rd_en);
         nwr += int'(m_wr_en);
         if (rel < n + 4) begin
            start = (rel == r1 || rel == r2);
            rst   = (rel == rst_at);
            tick();
            if (rel == rst_at) killed = 1'b1;
         end
      end
      start = 1'b0;
      rst   = 1'b0;
      if (!killed) begin
         chk("rd_count", 32'(nrd), 32'(n));
         chk("wr_count", 32'(nwr), 32'(n));
      end
   endtask

   initial begin
      // Reset state of both instances.
      rst = 1'b1;
      tick(); tick();
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         chk("rst_busy",   32'(m_busy),      32'd0);
         chk("rst_done",   32'(m_done),      32'd0);
         chk("rst_rd_en",  32'(m_rd_en),     32'd0);
         chk("rst_wr_en",  32'(m_wr_en),     32'd0);
         chk("rst_rvalid", 32'(m_red_valid), 32'd0);
         chk("rst_red_en", 32'(m_red_en),    32'd0);
      end
      sel = 1'b0;
      rst = 1'b0;
      tick(); tick();
      chk("red_en_on", 32'(red_en_a), 32'd1);
      chk("red_en_on_b", 32'(red_en_b), 32'd1);

      // N=8 directed boundary vector, in place.
      fill(1'b1);
      sweep(-1, -1, -1);
      check_mem();

      // Stray reducer valid while idle must not write.
      inj = 1'b1;
      #1;
      chk("idle_gate", 32'(m_wr_en), 32'd0);
      inj = 1'b0;
      tick();

      // Start re-pulsed at cycle 3 and in the done cycle, then a sweep at cycle 12.
      fill(1'b0);
      sweep(3, NA + 3, -1);
      check_mem();
      sweep(-1, -1, -1);
      check_mem();
      tick();

      // Reset at cycle 5, then a clean sweep.
      fill(1'b0);
      sweep(-1, -1, 5);
      tick(); tick();
      fill(1'b0);
      sweep(-1, -1, -1);
      check_mem();
      tick();

      // N=256, dst offset 512, back-to-back sweeps with new random source.
      sel = 1'b1;
      #1;
      fill(1'b0);
      sweep(-1, -1, -1);
      check_mem();
      fill(1'b0);
      sweep(-1, -1, -1);
      check_mem();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
